// File: rtl/sport_pkg.sv
// Shared definitions for the SPORT autobuffer engines: FSM encoding,
// register-select codes and default bus widths.
package sport_pkg;

  localparam int unsigned AW_DEF = 14;
  localparam int unsigned DW_DEF = 16;
  localparam int unsigned ST_W   = 4;
  localparam int unsigned SEL_W  = 2;

  // One-hot transfer FSM encoding
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 4'b0001,
    ST_REQ  = 4'b0010,
    ST_WAIT = 4'b0100,
    ST_ACK  = 4'b1000
  } state_e;

  typedef enum logic [SEL_W-1:0] {
    SEL_I    = 2'd0,
    SEL_M    = 2'd1,
    SEL_L    = 2'd2,
    SEL_RSVD = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/sport1_tx_autobuf_if.sv
// Signal bundle between the SPORT1 transmit autobuffer, the data-memory
// arbiter, the transmit controller and the processor register port.
interface sport1_tx_autobuf_if
  import sport_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  // Transmit controller side
  logic             TBUF;
  logic             TSreq;
  logic [DW-1:0]    TX_DATA;
  logic             TSack;
  logic             Twrap;
  logic             TUNDER;

  // Processor register write port
  logic             REG_WE;
  logic [SEL_W-1:0] REG_SEL;
  logic [AW-1:0]    REG_DI;

  // Data-memory arbiter side
  logic             DM_REQ;
  logic [AW-1:0]    DM_ADDR;
  logic             DM_GNT;
  logic [DW-1:0]    DM_RDATA;
  logic             DM_RVLD;

  modport slave (
    input  TBUF, TSreq, REG_WE, REG_SEL, REG_DI, DM_GNT, DM_RDATA, DM_RVLD,
    output DM_REQ, DM_ADDR, TX_DATA, TSack, Twrap, TUNDER
  );

  modport master (
    output TBUF, TSreq, REG_WE, REG_SEL, REG_DI, DM_GNT, DM_RDATA, DM_RVLD,
    input  DM_REQ, DM_ADDR, TX_DATA, TSack, Twrap, TUNDER
  );

endinterface

// File: rtl/sport_circ_addr.sv
// Circular-buffer post-modify: next index from I/M/L/BASE plus wrap flag.
// Purely combinational; shared with the receive autobuffer.
module sport_circ_addr
  import sport_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic [AW-1:0] idx_i,
  input  logic [AW-1:0] mod_i,
  input  logic [AW-1:0] len_i,
  input  logic [AW-1:0] base_i,
  output logic [AW-1:0] next_c_o,
  output logic          wrap_c_o
);

  logic [AW-1:0] sum_c;
  logic [AW:0]   limit_c;

  assign sum_c   = idx_i + mod_i;
  // Upper bound kept one bit wider so BASE+L near the top of memory cannot alias
  assign limit_c = {1'b0, base_i} + {1'b0, len_i};

  always_comb begin
    next_c_o = sum_c;
    wrap_c_o = 1'b0;
    if (len_i != '0) begin
      if (!mod_i[AW-1]) begin
        if ({1'b0, sum_c} >= limit_c) begin
          next_c_o = sum_c - len_i;
          wrap_c_o = 1'b1;
        end
      end else if (sum_c < base_i) begin
        next_c_o = sum_c + len_i;
        wrap_c_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sport1_tx_autobuf.sv
// SPORT1 transmit autobuffer: on each TSreq rising edge fetch the word at I
// from data memory, post-modify I circularly and hand the word over with TSack.
module sport1_tx_autobuf
  import sport_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic                DSPCLK,
  input  logic                RSTn,
  sport1_tx_autobuf_if.slave  bus
);

  state_e        state_q;
  logic [AW-1:0] i_q, m_q, l_q, base_q;
  logic [AW-1:0] i_d, m_d, l_d, base_d;
  logic          tsreq_q;
  logic          dm_req_q;
  logic [DW-1:0] tx_data_q;
  logic          tsack_q;
  logic          twrap_q;
  logic          tunder_q, tunder_d;
  logic          req_edge_c;
  logic          post_mod_c;
  logic [AW-1:0] next_i_c;
  logic          wrap_c;

  assign req_edge_c = bus.TSreq & ~tsreq_q;
  assign post_mod_c = (state_q == ST_WAIT) & bus.DM_RVLD;

  sport_circ_addr #(.AW(AW)) u_circ (
    .idx_i    (i_q),
    .mod_i    (m_q),
    .len_i    (l_q),
    .base_i   (base_q),
    .next_c_o (next_i_c),
    .wrap_c_o (wrap_c)
  );

  // Register file: a processor write always beats the post-modify of I
  always_comb begin
    i_d    = i_q;
    m_d    = m_q;
    l_d    = l_q;
    base_d = base_q;
    if (bus.REG_WE) begin
      case (reg_sel_e'(bus.REG_SEL))
        SEL_I: begin
          i_d    = bus.REG_DI;
          base_d = bus.REG_DI;
        end
        SEL_M:   m_d = bus.REG_DI;
        SEL_L:   l_d = bus.REG_DI;
        default: ;
      endcase
    end else if (post_mod_c) begin
      i_d = next_i_c;
    end
  end

  // Underrun flag: setting wins over the clear from a register write
  always_comb begin
    tunder_d = tunder_q;
    if (bus.REG_WE)
      tunder_d = 1'b0;
    if (req_edge_c && (state_q != ST_IDLE))
      tunder_d = 1'b1;
  end

  always_ff @(posedge DSPCLK or negedge RSTn) begin
    if (!RSTn) begin
      i_q      <= '0;
      m_q      <= '0;
      l_q      <= '0;
      base_q   <= '0;
      tsreq_q  <= 1'b0;
      tunder_q <= 1'b0;
    end else begin
      i_q      <= i_d;
      m_q      <= m_d;
      l_q      <= l_d;
      base_q   <= base_d;
      tsreq_q  <= bus.TSreq;
      tunder_q <= tunder_d;
    end
  end

  // Transfer FSM with registered handshake outputs
  always_ff @(posedge DSPCLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= ST_IDLE;
      dm_req_q  <= 1'b0;
      tx_data_q <= '0;
      tsack_q   <= 1'b0;
      twrap_q   <= 1'b0;
    end else begin
      tsack_q <= 1'b0;
      twrap_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_edge_c && bus.TBUF) begin
            state_q  <= ST_REQ;
            dm_req_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.DM_GNT) begin
            state_q  <= ST_WAIT;
            dm_req_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (bus.DM_RVLD) begin
            state_q   <= ST_ACK;
            tx_data_q <= bus.DM_RDATA;
            tsack_q   <= 1'b1;
            twrap_q   <= wrap_c;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          dm_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DM_REQ  = dm_req_q;
  assign bus.DM_ADDR = i_q;
  assign bus.TX_DATA = tx_data_q;
  assign bus.TSack   = tsack_q;
  assign bus.Twrap   = twrap_q;
  assign bus.TUNDER  = tunder_q;

endmodule
